// File: rtl/mem_transfer_engine.sv
// mem_transfer_engine
//   Fills source memory A from a valid-qualified input stream. Once A holds DEPTH words it
//   copies A into destination memory B using one of four transfer modes, then raises done.
//   Memory B has a registered read-back port that is live in every state.
//
// Ports
//   clk      : system clock, all logic on the rising edge
//   rst      : synchronous, active-high reset
//   dataInA  : write data for memory A
//   validA   : dataInA valid this cycle
//   readyA   : engine accepts a word (FILL only)
//   mode     : transfer mode, latched on entry to COPY
//              (0 copy, 1 reverse, 2 running sum, 3 invert)
//   restart  : in DONE, return to FILL for a new batch
//   rdAddrB  : read address for memory B
//   dataOutB : registered memory B read data (1-cycle latency, read-before-write)
//   busy     : high in COPY
//   done     : high in DONE
module mem_transfer_engine #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  dataInA,
  input  logic              validA,
  output logic              readyA,
  input  logic [1:0]        mode,
  input  logic              restart,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic [WIDTH-1:0]  dataOutB,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] AddrMax = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};
  // Copy index runs 0..DEPTH inclusive, so it needs one extra bit.
  localparam logic [ADDR_W:0]   LastIdx = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   IdxOne  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StFill, StCopy, StDone} state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [1:0]        mode_q, mode_d;
  logic [WIDTH-1:0]  rd_a_q, rd_a_d;
  logic [WIDTH-1:0]  dout_q, dout_d;

  logic [WIDTH-1:0]  mem_a [DEPTH];
  logic [WIDTH-1:0]  mem_b [DEPTH];

  logic              we_a;
  logic              we_b;
  logic [ADDR_W-1:0] waddr_b;
  logic [WIDTH-1:0]  wdata_b;
  logic [ADDR_W-1:0] src_idx;
  logic [WIDTH-1:0]  sum;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFill:  if (validA && (wr_ptr_q == AddrMax)) state_d = StCopy;
      StCopy:  if (idx_q == LastIdx) state_d = StDone;
      StDone:  if (restart) state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  // Outputs decode directly from state
  always_comb begin
    readyA = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state_q)
      StFill:  readyA = 1'b1;
      StCopy:  busy   = 1'b1;
      StDone:  done   = 1'b1;
      default: readyA = 1'b0;
    endcase
  end

  // Word written to B during copy cycle k belongs to source index k-1; at k=DEPTH the
  // truncated subtraction yields DEPTH-1 as required.
  assign src_idx = idx_q[ADDR_W-1:0] - AddrOne;
  assign sum     = acc_q + rd_a_q;

  // Datapath next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    mode_d   = mode_q;
    rd_a_d   = rd_a_q;
    we_a     = 1'b0;
    we_b     = 1'b0;
    waddr_b  = src_idx;
    wdata_b  = rd_a_q;
    dout_d   = mem_b[rdAddrB];

    case (state_q)
      StFill: begin
        if (validA) begin
          we_a     = 1'b1;
          wr_ptr_d = wr_ptr_q + AddrOne;
          if (wr_ptr_q == AddrMax) begin
            mode_d = mode;
            acc_d  = '0;
            idx_d  = '0;
          end
        end
      end
      StCopy: begin
        idx_d = idx_q + IdxOne;
        if (idx_q != LastIdx) begin
          rd_a_d = mem_a[idx_q[ADDR_W-1:0]];
        end
        if (idx_q != '0) begin
          we_b = 1'b1;
          case (mode_q)
            2'd1: begin
              // DEPTH-1-i is the bitwise inverse of i for a power-of-two depth.
              waddr_b = ~src_idx;
            end
            2'd2: begin
              wdata_b = sum;
              acc_d   = sum;
            end
            2'd3: wdata_b = ~rd_a_q;
            default: wdata_b = rd_a_q;
          endcase
        end
        // Leave the index cleared so a restart begins from a clean copy.
        if (idx_q == LastIdx) idx_d = '0;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      mode_q   <= '0;
      rd_a_q   <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      mode_q   <= mode_d;
      rd_a_q   <= rd_a_d;
      dout_q   <= dout_d;
    end
  end

  // Memory arrays are not reset; a reset edge suppresses any pending write.
  always_ff @(posedge clk) begin
    if (!rst && we_a) mem_a[wr_ptr_q] <= dataInA;
  end

  always_ff @(posedge clk) begin
    if (!rst && we_b) mem_b[waddr_b] <= wdata_b;
  end

  assign dataOutB = dout_q;

endmodule

// File: tb/tb_mem_transfer_engine.sv
module tb_mem_transfer_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dataInA;
  logic       validA;
  logic       readyA;
  logic [1:0] mode;
  logic       restart;
  logic [3:0] rdAddrB;
  logic [7:0] dataOutB;
  logic       busy;
  logic       done;

  int tests    = 0;
  int failures = 0;

  logic [7:0] vec  [16];
  logic [7:0] expb [16];

  mem_transfer_engine #(
    .WIDTH  (8),
    .ADDR_W (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dataInA  (dataInA),
    .validA   (validA),
    .readyA   (readyA),
    .mode     (mode),
    .restart  (restart),
    .rdAddrB  (rdAddrB),
    .dataOutB (dataOutB),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Streams vec[0..15] into A; optionally inserts 3 idle cycles before word gap_at,
  // with restart pulsed during the gap when pulse_restart is set.
  task automatic fill(input logic [1:0] m, input int gap_at, input bit pulse_restart);
    mode = m;
    for (int i = 0; i < 16; i++) begin
      if (i == gap_at) begin
        validA  = 1'b0;
        dataInA = 8'h99;
        restart = pulse_restart;
        repeat (3) step();
        restart = 1'b0;
        check("ready_after_gap", readyA, 1);
      end
      if (i == 15) check("ready_before_last", readyA, 1);
      dataInA = vec[i];
      validA  = 1'b1;
      step();
    end
    validA = 1'b0;
    check("ready_low_after_fill", readyA, 0);
    check("busy_after_fill", busy, 1);
  endtask

  // Runs COPY to completion; flips mode and optionally offers junk words meanwhile.
  task automatic run_copy(input bit hold_valid, input logic [7:0] junk);
    int n_busy = 0;
    int n_cyc  = 0;
    mode    = ~mode;
    validA  = hold_valid;
    dataInA = junk;
    while (!done && n_cyc < 40) begin
      if (busy) n_busy++;
      step();
      n_cyc++;
    end
    validA = 1'b0;
    check("busy_cycles", n_busy, 17);
    check("done_high", done, 1);
    check("busy_low_in_done", busy, 0);
    check("ready_low_in_done", readyA, 0);
  endtask

  task automatic read_b(input string tag);
    for (int a = 0; a < 16; a++) begin
      rdAddrB = 4'(a);
      step();
      check(tag, dataOutB, expb[a]);
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("restart_ready", readyA, 1);
    check("restart_done_low", done, 0);
  endtask

  initial begin
    rst     = 1'b1;
    dataInA = '0;
    validA  = 1'b0;
    mode    = 2'd0;
    restart = 1'b0;
    rdAddrB = '0;
    step();
    step();
    check("reset_ready", readyA, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_dout", dataOutB, 0);
    rst = 1'b0;

    // Mode 0: plain copy of 0..15
    for (int i = 0; i < 16; i++) vec[i] = 8'(i);
    fill(2'd0, -1, 1'b0);
    run_copy(1'b0, 8'h00);
    for (int i = 0; i < 16; i++) expb[i] = 8'(i);
    read_b("copy_mode0");

    // Mode 1: reverse
    do_restart();
    fill(2'd1, -1, 1'b0);
    run_copy(1'b0, 8'h00);
    for (int i = 0; i < 16; i++) expb[i] = 8'(15 - i);
    read_b("reverse_mode1");

    // Mode 2: running sum of ones
    do_restart();
    for (int i = 0; i < 16; i++) vec[i] = 8'h01;
    fill(2'd2, -1, 1'b0);
    run_copy(1'b0, 8'h00);
    for (int i = 0; i < 16; i++) expb[i] = 8'(i + 1);
    read_b("runsum_ones");

    // Mode 2: running sum of 0x80 wraps modulo 256
    do_restart();
    for (int i = 0; i < 16; i++) vec[i] = 8'h80;
    fill(2'd2, -1, 1'b0);
    run_copy(1'b0, 8'h00);
    for (int i = 0; i < 16; i++) expb[i] = (i % 2 == 0) ? 8'h80 : 8'h00;
    read_b("runsum_wrap");

    // Mode 3: invert
    do_restart();
    for (int i = 0; i < 16; i++) vec[i] = 8'h0F;
    fill(2'd3, -1, 1'b0);
    run_copy(1'b0, 8'h00);
    for (int i = 0; i < 16; i++) expb[i] = 8'hF0;
    read_b("invert_mode3");

    // Gaps in validA during FILL, junk offered throughout COPY
    do_restart();
    for (int i = 0; i < 16; i++) vec[i] = 8'(8'h20 + i);
    fill(2'd0, 8, 1'b0);
    run_copy(1'b1, 8'hEE);
    for (int i = 0; i < 16; i++) expb[i] = 8'(8'h20 + i);
    read_b("gap_fill");

    // Reset asserted during COPY cycle 5
    do_restart();
    for (int i = 0; i < 16; i++) vec[i] = 8'(i);
    fill(2'd0, -1, 1'b0);
    repeat (5) step();
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_ready", readyA, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_dout", dataOutB, 0);
    for (int i = 0; i < 16; i++) expb[i] = (i < 4) ? 8'(i) : 8'(8'h20 + i);
    read_b("abort_partial");

    // Fresh fill after abort, restart pulsed mid-FILL must be ignored
    fill(2'd3, 5, 1'b1);
    run_copy(1'b0, 8'h00);
    for (int i = 0; i < 16; i++) expb[i] = ~8'(i);
    read_b("after_abort_invert");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
